// File: rtl/adder_pkg.sv
// Shared widths and reset values for the registered 4-bit adder.
// Imported by the adder top level.
package adder_pkg;

  localparam int ADD_W   = 4;
  localparam int CARRY_W = ADD_W + 1;

  localparam logic [ADD_W-1:0]   SUM_RST   = '0;
  localparam logic [CARRY_W-1:0] CARRY_RST = '0;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell.
// Purely combinational; chained by the adder top level.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder.
// Exposes the full carry chain for overflow inspection.
module four_bit_adder
  import adder_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   input_1,
  input  logic [3:0]   input_2,
  input  logic         c_in,
  output logic [3:0]   sum,
  output logic [4:0]   carry
);

  logic [CARRY_W-1:0] c;
  logic [ADD_W-1:0]   s;

  assign c[0] = c_in;

  for (genvar i = 0; i < ADD_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (input_1[i]),
      .b    (input_2[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= SUM_RST;
      carry <= CARRY_RST;
    end else begin
      sum   <= s;
      carry <= c;
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder.
// Directed, exhaustive and random stimulus against an arithmetic model.
module tb_four_bit_adder;

  logic       clk;
  logic       rst_n;
  logic [3:0] input_1;
  logic [3:0] input_2;
  logic       c_in;
  logic [3:0] sum;
  logic [4:0] carry;

  int total;
  int bad;

  four_bit_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .input_1 (input_1),
    .input_2 (input_2),
    .c_in    (c_in),
    .sum     (sum),
    .carry   (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry into bit k is the overflow of adding the low k bits.
  function automatic logic [4:0] ref_carry(int a, int b, int ci);
    logic [4:0] r;
    r[0] = 1'(ci);
    for (int k = 1; k <= 4; k++) begin
      int m;
      m = (1 << k) - 1;
      r[k] = 1'((((a & m) + (b & m) + ci) >> k) & 1);
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_sum(int a, int b, int ci);
    return 4'((a + b + ci) % 16);
  endfunction

  task automatic drive(int a, int b, int ci);
    input_1 = 4'(a);
    input_2 = 4'(b);
    c_in    = 1'(ci);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(1)));
      @(posedge clk);
      #1;
      total++;
      if (sum !== 4'b0000 || carry !== 5'b00000) begin
        bad++;
        $display("FAIL reset_hold: sum=%b carry=%b want 0000 00000",
                 sum, carry);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int ta[9] = '{5, 5, 8, 8, 7, 7, 15, 15, 0};
    int tb[9] = '{3, 3, 4, 4, 7, 7, 1, 15, 0};
    int tc[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic [3:0] ts[9] = '{4'b1000, 4'b1001, 4'b1100, 4'b1101,
                          4'b1110, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
    logic [4:0] tk[9] = '{5'b01110, 5'b01111, 5'b00000, 5'b00001,
                          5'b01110, 5'b01111, 5'b11110, 5'b11111,
                          5'b00000};
    for (int k = 0; k < 9; k++) begin
      drive(ta[k], tb[k], tc[k]);
      @(posedge clk);
      #1;
      total++;
      if (sum !== ts[k] || carry !== tk[k]) begin
        bad++;
        $display("FAIL directed_%0d: %0d+%0d+%0d sum=%b carry=%b want %b %b",
                 k, ta[k], tb[k], tc[k], sum, carry, ts[k], tk[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] prev_s;
    logic [4:0] prev_c;
    int a, b, ci;
    for (int i = 0; i < 512; i++) begin
      a  = i & 15;
      b  = (i >> 4) & 15;
      ci = (i >> 8) & 1;
      drive(a, b, ci);
      if (i > 0) begin
        @(negedge clk);
        total++;
        if (sum !== prev_s || carry !== prev_c) begin
          bad++;
          $display("FAIL latency_%0d: sum=%b carry=%b want held %b %b",
                   i, sum, carry, prev_s, prev_c);
        end
      end
      @(posedge clk);
      #1;
      total++;
      if ({carry[4], sum} !== 5'(a + b + ci)) begin
        bad++;
        $display("FAIL identity %0d+%0d+%0d: got %0d want %0d",
                 a, b, ci, {carry[4], sum}, a + b + ci);
      end
      total++;
      if (carry !== ref_carry(a, b, ci) || sum !== ref_sum(a, b, ci)) begin
        bad++;
        $display("FAIL chain %0d+%0d+%0d: sum=%b carry=%b want %b %b",
                 a, b, ci, sum, carry, ref_sum(a, b, ci),
                 ref_carry(a, b, ci));
      end
      prev_s = ref_sum(a, b, ci);
      prev_c = ref_carry(a, b, ci);
    end
  endtask

  task automatic test_async_reset();
    int a, b, ci;
    drive(15, 15, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (sum !== 4'b0000 || carry !== 5'b00000) begin
      bad++;
      $display("FAIL async_clear: sum=%b carry=%b want 0000 00000",
               sum, carry);
    end
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (sum !== 4'b0000 || carry !== 5'b00000) begin
      bad++;
      $display("FAIL release_stale: sum=%b carry=%b want 0000 00000",
               sum, carry);
    end
    a  = int'($urandom_range(15));
    b  = int'($urandom_range(15));
    ci = int'($urandom_range(1));
    drive(a, b, ci);
    @(posedge clk);
    #1;
    total++;
    if (sum !== ref_sum(a, b, ci) || carry !== ref_carry(a, b, ci)) begin
      bad++;
      $display("FAIL first_capture: sum=%b carry=%b want %b %b",
               sum, carry, ref_sum(a, b, ci), ref_carry(a, b, ci));
    end
  endtask

  task automatic test_random();
    int a, b, ci;
    for (int k = 0; k < 200; k++) begin
      a  = int'($urandom_range(15));
      b  = int'($urandom_range(15));
      ci = int'($urandom_range(1));
      drive(a, b, ci);
      @(posedge clk);
      #1;
      total++;
      if (sum !== ref_sum(a, b, ci) || carry !== ref_carry(a, b, ci)) begin
        bad++;
        $display("FAIL random %0d+%0d+%0d: sum=%b carry=%b want %b %b",
                 a, b, ci, sum, carry, ref_sum(a, b, ci),
                 ref_carry(a, b, ci));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, 0, 0);
    #1;
    total++;
    if (sum !== 4'b0000 || carry !== 5'b00000) begin
      bad++;
      $display("FAIL reset_initial: sum=%b carry=%b want 0000 00000",
               sum, carry);
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
